// File: rtl/axi_rd_arbiter.sv
// Two-master AXI4 read-channel arbiter: one burst in flight, combinational R routing, RLAST cross-check.
// Define AXI_RD_ARB_RR_EN for round-robin tie-breaking; default build is fixed priority (M0 wins ties).
module axi_rd_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [ADDR_WIDTH-1:0] m0_ARADDR,
  input  logic [7:0]            m0_ARLEN,
  input  logic [2:0]            m0_ARSIZE,
  input  logic                  m0_ARVALID,
  output logic                  m0_ARREADY,
  output logic [DATA_WIDTH-1:0] m0_RDATA,
  output logic [1:0]            m0_RRESP,
  output logic                  m0_RLAST,
  output logic                  m0_RVALID,
  input  logic                  m0_RREADY,
  input  logic [ADDR_WIDTH-1:0] m1_ARADDR,
  input  logic [7:0]            m1_ARLEN,
  input  logic [2:0]            m1_ARSIZE,
  input  logic                  m1_ARVALID,
  output logic                  m1_ARREADY,
  output logic [DATA_WIDTH-1:0] m1_RDATA,
  output logic [1:0]            m1_RRESP,
  output logic                  m1_RLAST,
  output logic                  m1_RVALID,
  input  logic                  m1_RREADY,
  output logic [ADDR_WIDTH-1:0] s_ARADDR,
  output logic [7:0]            s_ARLEN,
  output logic [2:0]            s_ARSIZE,
  output logic                  s_ARVALID,
  input  logic                  s_ARREADY,
  input  logic [DATA_WIDTH-1:0] s_RDATA,
  input  logic [1:0]            s_RRESP,
  input  logic                  s_RLAST,
  input  logic                  s_RVALID,
  output logic                  s_RREADY,
  output logic                  gnt,
  output logic                  busy,
  output logic                  rlast_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] hold_addr;
  logic [7:0]            hold_len;
  logic [2:0]            hold_size;
  logic [7:0]            beat_cnt;
  logic                  win;
  logic                  grant;
  logic                  in_data;
  logic                  sel_rready;
  logic                  r_hs;
  logic                  cnt_zero;

`ifdef AXI_RD_ARB_RR_EN
  logic rr_last;

  // On a tie the master that did not win last time is served.
  always_comb begin
    win = m1_ARVALID;
    if (m0_ARVALID && m1_ARVALID) win = ~rr_last;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET)     rr_last <= 1'b1;
    else if (grant) rr_last <= win;
  end
`else
  always_comb begin
    win = m1_ARVALID & ~m0_ARVALID;
  end
`endif

  // ARREADY is masked during reset so every output sits at its reset value.
  assign grant      = (state == ST_IDLE) && (m0_ARVALID || m1_ARVALID) && !ARESET;
  assign m0_ARREADY = grant & ~win;
  assign m1_ARREADY = grant & win;

  assign in_data    = (state == ST_DATA);
  assign sel_rready = gnt ? m1_RREADY : m0_RREADY;
  assign s_RREADY   = in_data & sel_rready;
  assign r_hs       = s_RVALID & s_RREADY;
  assign cnt_zero   = (beat_cnt == 8'd0);

  assign s_ARVALID  = (state == ST_ADDR);
  assign s_ARADDR   = hold_addr;
  assign s_ARLEN    = hold_len;
  assign s_ARSIZE   = hold_size;
  assign busy       = (state != ST_IDLE);

  assign m0_RVALID  = in_data & ~gnt & s_RVALID;
  assign m0_RDATA   = (in_data && !gnt) ? s_RDATA : '0;
  assign m0_RRESP   = (in_data && !gnt) ? s_RRESP : 2'b00;
  assign m0_RLAST   = in_data & ~gnt & s_RLAST;
  assign m1_RVALID  = in_data & gnt & s_RVALID;
  assign m1_RDATA   = (in_data && gnt) ? s_RDATA : '0;
  assign m1_RRESP   = (in_data && gnt) ? s_RRESP : 2'b00;
  assign m1_RLAST   = in_data & gnt & s_RLAST;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state     <= ST_IDLE;
      hold_addr <= '0;
      hold_len  <= 8'd0;
      hold_size <= 3'd0;
      gnt       <= 1'b0;
      beat_cnt  <= 8'd0;
      rlast_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant) begin
            hold_addr <= win ? m1_ARADDR : m0_ARADDR;
            hold_len  <= win ? m1_ARLEN  : m0_ARLEN;
            hold_size <= win ? m1_ARSIZE : m0_ARSIZE;
            beat_cnt  <= win ? m1_ARLEN  : m0_ARLEN;
            gnt       <= win;
            state     <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (s_ARREADY) state <= ST_DATA;
        end
        ST_DATA: begin
          if (r_hs) begin
            // Counter saturates at zero so surplus beats keep flagging.
            if (!cnt_zero) beat_cnt <= beat_cnt - 8'd1;
            if (cnt_zero != s_RLAST) rlast_err <= 1'b1;
            if (s_RLAST) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: vector table, directed burst sequences and a randomized transaction-level scoreboard.
module tb_axi_rd_arbiter;

`ifdef AXI_RD_ARB_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic        ACLK, ARESET;
  logic [15:0] m0_ARADDR, m1_ARADDR, s_ARADDR;
  logic [7:0]  m0_ARLEN, m1_ARLEN, s_ARLEN;
  logic [2:0]  m0_ARSIZE, m1_ARSIZE, s_ARSIZE;
  logic        m0_ARVALID, m1_ARVALID, m0_ARREADY, m1_ARREADY;
  logic [31:0] m0_RDATA, m1_RDATA, s_RDATA;
  logic [1:0]  m0_RRESP, m1_RRESP, s_RRESP;
  logic        m0_RLAST, m1_RLAST, s_RLAST;
  logic        m0_RVALID, m1_RVALID, s_RVALID;
  logic        m0_RREADY, m1_RREADY, s_RREADY;
  logic        s_ARVALID, s_ARREADY;
  logic        gnt, busy, rlast_err;

  int nchk = 0;
  int nerr = 0;

  axi_rd_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .m0_ARADDR(m0_ARADDR), .m0_ARLEN(m0_ARLEN), .m0_ARSIZE(m0_ARSIZE),
    .m0_ARVALID(m0_ARVALID), .m0_ARREADY(m0_ARREADY),
    .m0_RDATA(m0_RDATA), .m0_RRESP(m0_RRESP), .m0_RLAST(m0_RLAST),
    .m0_RVALID(m0_RVALID), .m0_RREADY(m0_RREADY),
    .m1_ARADDR(m1_ARADDR), .m1_ARLEN(m1_ARLEN), .m1_ARSIZE(m1_ARSIZE),
    .m1_ARVALID(m1_ARVALID), .m1_ARREADY(m1_ARREADY),
    .m1_RDATA(m1_RDATA), .m1_RRESP(m1_RRESP), .m1_RLAST(m1_RLAST),
    .m1_RVALID(m1_RVALID), .m1_RREADY(m1_RREADY),
    .s_ARADDR(s_ARADDR), .s_ARLEN(s_ARLEN), .s_ARSIZE(s_ARSIZE),
    .s_ARVALID(s_ARVALID), .s_ARREADY(s_ARREADY),
    .s_RDATA(s_RDATA), .s_RRESP(s_RRESP), .s_RLAST(s_RLAST),
    .s_RVALID(s_RVALID), .s_RREADY(s_RREADY),
    .gnt(gnt), .busy(busy), .rlast_err(rlast_err)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    m0_ARVALID = 0; m1_ARVALID = 0; s_ARREADY = 0; s_RVALID = 0; s_RLAST = 0;
    m0_RREADY = 0; m1_RREADY = 0; s_RDATA = '0; s_RRESP = 2'b00;
  endtask

  task automatic do_reset();
    @(negedge ACLK);
    ARESET = 1;
    clear_inputs();
    @(negedge ACLK);
    ARESET = 0;
  endtask

  // Starts at a negedge in IDLE; ends at the negedge of the ADDR cycle.
  task automatic request(input int m, input logic [15:0] a, input logic [7:0] l, input logic [2:0] s);
    if (m == 0) begin m0_ARVALID = 1; m0_ARADDR = a; m0_ARLEN = l; m0_ARSIZE = s; end
    else        begin m1_ARVALID = 1; m1_ARADDR = a; m1_ARLEN = l; m1_ARSIZE = s; end
    #1;
    chk("req_arready_win", (m == 0) ? m0_ARREADY : m1_ARREADY, 1);
    chk("req_arready_lose", (m == 0) ? m1_ARREADY : m0_ARREADY, 0);
    @(negedge ACLK);
    m0_ARVALID = 0; m1_ARVALID = 0;
  endtask

  task automatic addr_hs(input int m, input logic [15:0] a, input logic [7:0] l, input logic [2:0] s);
    s_ARREADY = 1;
    #1;
    chk("addr_arvalid", s_ARVALID, 1);
    chk("addr_araddr", s_ARADDR, a);
    chk("addr_arlen", s_ARLEN, l);
    chk("addr_arsize", s_ARSIZE, s);
    chk("addr_gnt", gnt, m);
    chk("addr_busy", busy, 1);
    @(negedge ACLK);
    s_ARREADY = 0;
  endtask

  task automatic beat(input int m, input logic [31:0] d, input bit last, input bit rdy);
    s_RVALID = 1; s_RDATA = d; s_RLAST = last; s_RRESP = 2'b01;
    if (m == 0) m0_RREADY = rdy; else m1_RREADY = rdy;
    #1;
    chk("beat_rvalid", (m == 0) ? m0_RVALID : m1_RVALID, 1);
    chk("beat_other_rvalid", (m == 0) ? m1_RVALID : m0_RVALID, 0);
    chk("beat_rdata", (m == 0) ? m0_RDATA : m1_RDATA, d);
    chk("beat_rlast", (m == 0) ? m0_RLAST : m1_RLAST, last);
    chk("beat_rresp", (m == 0) ? m0_RRESP : m1_RRESP, 2'b01);
    chk("beat_s_rready", s_RREADY, rdy);
    @(negedge ACLK);
    s_RVALID = 0; s_RLAST = 0; m0_RREADY = 0; m1_RREADY = 0;
  endtask

  typedef struct {
    bit          v0, v1;
    logic [15:0] a0, a1;
    bit          e_rdy0, e_rdy1, e_busy, e_gnt;
    logic [15:0] e_addr;
  } arb_vec_t;

  arb_vec_t vecs[4];

  function automatic logic [31:0] beat_data(input logic [15:0] a, input int i);
    logic [7:0] ib;
    ib = i[7:0];
    return {a, 8'h5A, ib};
  endfunction

  // Randomized scoreboard state, kept at burst/transaction level.
  bit          pend[2];
  logic [15:0] ra[2];
  logic [7:0]  rl[2];
  logic [2:0]  rs[2];
  bit          rrdy[2];
  bit          mdl_busy, mdl_last, ar_wait, r_active;
  int          cur_m, idx, w, grants[2];
  logic [15:0] cur_a;
  logic [7:0]  cur_l;
  logic [2:0]  cur_s;

  initial begin
    ARESET = 1;
    m0_ARADDR = '0; m1_ARADDR = '0; m0_ARLEN = '0; m1_ARLEN = '0; m0_ARSIZE = '0; m1_ARSIZE = '0;
    clear_inputs();
    m0_ARVALID = 1;
    #12;
    chk("rst_s_arvalid", s_ARVALID, 0);
    chk("rst_s_rready", s_RREADY, 0);
    chk("rst_m0_arready", m0_ARREADY, 0);
    chk("rst_m1_arready", m1_ARREADY, 0);
    chk("rst_rvalid", {m0_RVALID, m1_RVALID}, 0);
    chk("rst_s_ar", {s_ARADDR, s_ARLEN, s_ARSIZE}, 0);
    chk("rst_m_rdata", {m0_RDATA, m1_RDATA, m0_RRESP, m1_RRESP, m0_RLAST, m1_RLAST}, 0);
    chk("rst_flags", {gnt, busy, rlast_err}, 0);
    m0_ARVALID = 0;
    @(negedge ACLK);
    ARESET = 0;

    // Single-cycle arbitration table, each from a fresh reset (rr_last = 1 so M0 wins ties in both modes).
    vecs[0] = '{v0:0, v1:0, a0:16'h1111, a1:16'h2222, e_rdy0:0, e_rdy1:0, e_busy:0, e_gnt:0, e_addr:16'h0000};
    vecs[1] = '{v0:1, v1:0, a0:16'h1111, a1:16'h2222, e_rdy0:1, e_rdy1:0, e_busy:1, e_gnt:0, e_addr:16'h1111};
    vecs[2] = '{v0:0, v1:1, a0:16'h1111, a1:16'h2222, e_rdy0:0, e_rdy1:1, e_busy:1, e_gnt:1, e_addr:16'h2222};
    vecs[3] = '{v0:1, v1:1, a0:16'h1111, a1:16'h2222, e_rdy0:1, e_rdy1:0, e_busy:1, e_gnt:0, e_addr:16'h1111};
    for (int i = 0; i < 4; i++) begin
      do_reset();
      m0_ARVALID = vecs[i].v0; m1_ARVALID = vecs[i].v1;
      m0_ARADDR = vecs[i].a0; m1_ARADDR = vecs[i].a1; m0_ARLEN = 8'd0; m1_ARLEN = 8'd0;
      #1;
      chk("vec_arready0", m0_ARREADY, vecs[i].e_rdy0);
      chk("vec_arready1", m1_ARREADY, vecs[i].e_rdy1);
      @(negedge ACLK);
      m0_ARVALID = 0; m1_ARVALID = 0;
      #1;
      chk("vec_busy", busy, vecs[i].e_busy);
      chk("vec_s_arvalid", s_ARVALID, vecs[i].e_busy);
      chk("vec_gnt", gnt, vecs[i].e_gnt);
      chk("vec_s_araddr", s_ARADDR, vecs[i].e_addr);
    end

    // M0 alone, 4-beat burst.
    do_reset();
    request(0, 16'h0010, 8'd3, 3'd2);
    addr_hs(0, 16'h0010, 8'd3, 3'd2);
    for (int i = 0; i < 4; i++) beat(0, 32'hA0 + i, i == 3, 1'b1);
    #1;
    chk("t1_idle_after_last", busy, 0);
    chk("t1_rlast_err", rlast_err, 0);

    // Three back-to-back ties with ARLEN=0.
    do_reset();
    m0_ARADDR = 16'h00A0; m1_ARADDR = 16'h00B0; m0_ARLEN = 0; m1_ARLEN = 0; m0_ARSIZE = 0; m1_ARSIZE = 0;
    for (int k = 0; k < 3; k++) begin
      int ew;
      ew = RR_MODE ? (k % 2) : 0;
      m0_ARVALID = 1; m1_ARVALID = 1;
      #1;
      chk("tie_arready0", m0_ARREADY, ew == 0);
      chk("tie_arready1", m1_ARREADY, ew == 1);
      @(negedge ACLK);
      s_ARREADY = 1;
      #1;
      chk("tie_gnt", gnt, ew);
      chk("tie_arready_busy", {m0_ARREADY, m1_ARREADY}, 0);
      chk("tie_araddr", s_ARADDR, ew ? 16'h00B0 : 16'h00A0);
      @(negedge ACLK);
      s_ARREADY = 0; s_RVALID = 1; s_RLAST = 1; s_RDATA = 32'hC0 + k; m0_RREADY = 1; m1_RREADY = 1;
      #1;
      chk("tie_rvalid", ew ? m1_RVALID : m0_RVALID, 1);
      chk("tie_rdata", ew ? m1_RDATA : m0_RDATA, 32'hC0 + k);
      @(negedge ACLK);
      s_RVALID = 0; s_RLAST = 0;
    end
    clear_inputs();

    // Slave stalls AR for 5 cycles.
    do_reset();
    request(1, 16'h1234, 8'd2, 3'd1);
    for (int c = 0; c < 5; c++) begin
      s_ARREADY = 0; s_RVALID = 1; s_RDATA = 32'hDEAD; m1_RREADY = 1;
      #1;
      chk("stall_ar", {s_ARVALID, s_ARADDR, s_ARLEN, s_ARSIZE}, {1'b1, 16'h1234, 8'd2, 3'd1});
      chk("stall_no_r", {m0_RVALID, m1_RVALID, s_RREADY}, 0);
      @(negedge ACLK);
    end
    s_RVALID = 0; m1_RREADY = 0;
    addr_hs(1, 16'h1234, 8'd2, 3'd1);
    for (int i = 0; i < 3; i++) beat(1, 32'h300 + i, i == 2, 1'b1);
    #1;
    chk("stall_rlast_err", rlast_err, 0);

    // m1_RREADY toggling during a 2-beat burst.
    do_reset();
    request(1, 16'h2000, 8'd1, 3'd2);
    addr_hs(1, 16'h2000, 8'd1, 3'd2);
    begin
      int hs;
      hs = 0;
      for (int c = 0; c < 4; c++) begin
        m1_RREADY = (c % 2 == 0);
        s_RVALID = (hs < 2); s_RDATA = 32'h400 + hs; s_RLAST = (hs == 1);
        #1;
        chk("tog_s_rready", s_RREADY, (hs < 2) && m1_RREADY);
        if (hs < 2) chk("tog_rdata", m1_RDATA, 32'h400 + hs);
        if (s_RVALID && s_RREADY) hs++;
        @(negedge ACLK);
      end
      chk("tog_handshakes", hs, 2);
      #1;
      chk("tog_idle", busy, 0);
      chk("tog_rlast_err", rlast_err, 0);
    end
    clear_inputs();

    // Early RLAST on beat 2 of a 4-beat burst.
    do_reset();
    request(0, 16'h3000, 8'd3, 3'd2);
    addr_hs(0, 16'h3000, 8'd3, 3'd2);
    beat(0, 32'h1, 1'b0, 1'b1);
    #1;
    chk("early_no_err_yet", rlast_err, 0);
    @(negedge ACLK);
    beat(0, 32'h2, 1'b1, 1'b1);
    #1;
    chk("early_err", rlast_err, 1);
    chk("early_idle", busy, 0);
    repeat (3) @(negedge ACLK);
    #1;
    chk("early_err_sticky", rlast_err, 1);

    // Surplus beat after the count reaches zero.
    do_reset();
    request(1, 16'h3100, 8'd1, 3'd2);
    addr_hs(1, 16'h3100, 8'd1, 3'd2);
    beat(1, 32'h11, 1'b0, 1'b1);
    beat(1, 32'h12, 1'b0, 1'b1);
    #1;
    chk("extra_err", rlast_err, 1);
    chk("extra_still_busy", busy, 1);
    @(negedge ACLK);
    beat(1, 32'h13, 1'b1, 1'b1);
    #1;
    chk("extra_idle", busy, 0);
    chk("extra_err_sticky", rlast_err, 1);
    @(negedge ACLK);

    // Reset during beat 1 of an 8-beat burst.
    do_reset();
    request(0, 16'h0700, 8'd7, 3'd0);
    addr_hs(0, 16'h0700, 8'd7, 3'd0);
    s_RVALID = 1; s_RDATA = 32'h77; m0_RREADY = 1;
    #1;
    chk("mid_rvalid", m0_RVALID, 1);
    ARESET = 1;
    #1;
    chk("mid_rst_ctrl", {s_ARVALID, s_RREADY, m0_ARREADY, m1_ARREADY, m0_RVALID, m1_RVALID}, 0);
    chk("mid_rst_data", {m0_RDATA, m0_RLAST, s_ARADDR, s_ARLEN}, 0);
    chk("mid_rst_flags", {gnt, busy, rlast_err}, 0);
    @(negedge ACLK);
    ARESET = 0;
    clear_inputs();
    request(1, 16'h0BEE, 8'd0, 3'd3);
    addr_hs(1, 16'h0BEE, 8'd0, 3'd3);
    beat(1, 32'h88, 1'b1, 1'b1);
    #1;
    chk("mid_after_idle", busy, 0);

    // Randomized traffic against the transaction-level model.
    do_reset();
    pend[0] = 0; pend[1] = 0; mdl_busy = 0; mdl_last = 1; ar_wait = 0; r_active = 0;
    cur_m = 0; idx = 0; cur_a = '0; cur_l = '0; cur_s = '0; grants[0] = 0; grants[1] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit exp_any, own_rdy;
      logic [31:0] r32;
      if (cyc > 0) @(negedge ACLK);
      for (int m = 0; m < 2; m++) begin
        if (!pend[m] && cyc < 2700 && $urandom_range(0, 2) == 0) begin
          pend[m] = 1;
          r32 = $urandom;
          ra[m] = r32[15:0];
          rl[m] = 8'($urandom_range(0, 3));
          rs[m] = 3'($urandom_range(0, 2));
        end
        rrdy[m] = ($urandom_range(0, 3) != 0);
      end
      m0_ARVALID = pend[0]; m0_ARADDR = ra[0]; m0_ARLEN = rl[0]; m0_ARSIZE = rs[0];
      m1_ARVALID = pend[1]; m1_ARADDR = ra[1]; m1_ARLEN = rl[1]; m1_ARSIZE = rs[1];
      m0_RREADY = rrdy[0]; m1_RREADY = rrdy[1];
      s_ARREADY = ($urandom_range(0, 2) != 0);
      if (r_active) begin
        s_RVALID = ($urandom_range(0, 3) != 0);
        s_RDATA = beat_data(cur_a, idx);
        s_RLAST = (idx == int'(cur_l));
        s_RRESP = 2'(idx);
      end else begin
        s_RVALID = 0; s_RLAST = 0; s_RDATA = '0; s_RRESP = 2'b00;
      end
      #1;
      chk("rnd_busy", busy, mdl_busy);
      exp_any = !mdl_busy && (pend[0] || pend[1]);
      if (pend[0] && pend[1]) w = RR_MODE ? int'(!mdl_last) : 0;
      else w = pend[1] ? 1 : 0;
      chk("rnd_arready0", m0_ARREADY, exp_any && w == 0);
      chk("rnd_arready1", m1_ARREADY, exp_any && w == 1);
      if (ar_wait) begin
        chk("rnd_ar", {s_ARVALID, s_ARADDR, s_ARLEN, s_ARSIZE}, {1'b1, cur_a, cur_l, cur_s});
        chk("rnd_gnt", gnt, cur_m);
      end else begin
        chk("rnd_arvalid_low", s_ARVALID, 0);
      end
      own_rdy = rrdy[cur_m];
      if (r_active) begin
        chk("rnd_own_rvalid", (cur_m == 0) ? m0_RVALID : m1_RVALID, s_RVALID);
        chk("rnd_oth_rvalid", (cur_m == 0) ? m1_RVALID : m0_RVALID, 0);
        chk("rnd_s_rready", s_RREADY, own_rdy);
        if (s_RVALID) begin
          chk("rnd_rdata", (cur_m == 0) ? m0_RDATA : m1_RDATA, beat_data(cur_a, idx));
          chk("rnd_rlast", (cur_m == 0) ? m0_RLAST : m1_RLAST, idx == int'(cur_l));
        end
        if (s_RVALID && own_rdy) begin
          if (idx == int'(cur_l)) begin r_active = 0; mdl_busy = 0; end
          else idx++;
        end
      end else begin
        chk("rnd_no_rvalid", {m0_RVALID, m1_RVALID, s_RREADY}, 0);
      end
      if (ar_wait && s_ARREADY) begin
        ar_wait = 0; r_active = 1; idx = 0;
      end
      if (exp_any) begin
        cur_m = w; cur_a = ra[w]; cur_l = rl[w]; cur_s = rs[w];
        mdl_last = (w == 1); pend[w] = 0; mdl_busy = 1; ar_wait = 1;
        grants[w]++;
      end
    end
    @(negedge ACLK);
    clear_inputs();
    #1;
    chk("rnd_final_busy", busy, 0);
    chk("rnd_final_rlast_err", rlast_err, 0);
    chk("rnd_both_served", (grants[0] > 0) && (grants[1] > 0), 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
